// File: rtl/serial_addr.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per cycle, LSB digit first.
// Latency WIDTH/DIGIT cycles after start; start is ignored while busy, no queuing.

module full_addr (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_addr #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_addr: DIGIT must be in 1..WIDTH and divide WIDTH; WIDTH must be >= 2");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;

  logic [DIGIT:0]   c_d;
  logic [DIGIT-1:0] dsum_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  // One digit of ripple carry; c_d[DIGIT-1] is the carry into the digit's top bit,
  // which on the final digit is the carry into bit WIDTH-1.
  assign c_d[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_addr u_fa (
      .a_i (a_q[i]),
      .b_i (b_q[i]),
      .c_i (c_d[i]),
      .s_o (dsum_d[i]),
      .c_o (c_d[i+1])
    );
  end

  assign res_d  = (res_q >> DIGIT) | (WIDTH'(dsum_d) << (WIDTH - DIGIT));
  assign last_d = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1, so the inversion and the +1 are folded in at load.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= c_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            s_q     <= res_d;
            cout_q  <= c_d[DIGIT];
            ovf_q   <= c_d[DIGIT] ^ c_d[DIGIT-1];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addr.sv
// Bench for serial_addr: directed table and corner sequences on WIDTH=16/DIGIT=4,
// plus concurrent random sweeps over other WIDTH/DIGIT pairs against an arithmetic model.
module tb_serial_addr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sweep_left = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model from plain integer arithmetic: unsigned result for s/cout, signed range for ovf.
  function automatic void ref_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input bit c, input bit sb, output logic [15:0] es,
                                    output bit ec, output bit eo);
    longint m, ua, ub, sa, sbv, r, sr;
    m   = longint'(1) << w;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (sb) begin
      r  = ua - ub;
      ec = (ua >= ub);
      sr = sa - sbv;
    end else begin
      r  = ua + ub + longint'(c);
      ec = (r >= m);
      sr = sa + sbv + longint'(c);
    end
    r  = ((r % m) + m) % m;
    es = 16'(r);
    eo = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  // Main instance for directed tests
  logic        rst, start, sub, cin, busy, done, cout, ovf;
  logic [15:0] a, b, s;

  serial_addr #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    bit          sb;
    logic [15:0] av;
    logic [15:0] bv;
    bit          c;
    logic [15:0] es;
    bit          ec;
    bit          eo;
  } vec_t;

  vec_t tbl[9];

  // Present operands, let one edge accept them, then scramble inputs to prove they were latched.
  task automatic apply_start(input bit sb, input logic [15:0] av, input logic [15:0] bv, input bit c);
    sub = sb; a = av; b = bv; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sub = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, cyc;
    logic [15:0] got_s;
    logic        got_c, got_o;

    tbl[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset s", 32'(s), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      apply_start(tbl[i].sb, tbl[i].av, tbl[i].bv, tbl[i].c);
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      done_at  = -1;
      got_s = 'x; got_c = 1'bx; got_o = 1'bx;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        busy_cnt += busy ? 1 : 0;
        if (done) begin
          done_cnt++;
          if (done_at < 0) begin
            done_at = k;
            got_s = s; got_c = cout; got_o = ovf;
          end
        end
      end
      chk($sformatf("vec%0d done latency", i), 32'(done_at), 32'd4);
      chk($sformatf("vec%0d done width", i), 32'(done_cnt), 32'd1);
      chk($sformatf("vec%0d busy cycles", i), 32'(busy_cnt), 32'd4);
      chk($sformatf("vec%0d s", i), 32'(got_s), 32'(tbl[i].es));
      chk($sformatf("vec%0d cout,ovf", i), 32'({got_c, got_o}), 32'({tbl[i].ec, tbl[i].eo}));
      chk($sformatf("vec%0d s held", i), 32'(s), 32'(tbl[i].es));
    end

    // start while busy must be ignored
    apply_start(1'b0, 16'h1234, 16'h4321, 1'b0);
    start = 1'b1; sub = 1'b1; a = 16'hFFFF; b = 16'h0F0F;
    done_cnt = 0;
    got_s = 'x;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) start = 1'b0;
      if (done) begin
        done_cnt++;
        got_s = s;
      end
    end
    chk("busy-start done count", 32'(done_cnt), 32'd1);
    chk("busy-start s", 32'(got_s), 32'h5555);
    chk("busy-start no queued op", 32'(busy), 32'd0);

    // back-to-back: new start accepted in the done cycle
    apply_start(1'b0, 16'h1111, 16'h2222, 1'b0);
    wait_done(10, cyc);
    chk("b2b first latency", 32'(cyc), 32'd4);
    chk("b2b first s", 32'(s), 32'h3333);
    apply_start(1'b0, 16'h0001, 16'h0001, 1'b0);
    chk("b2b done cleared", 32'(done), 32'd0);
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b old s held", 32'(s), 32'h3333);
    wait_done(10, cyc);
    chk("b2b second latency", 32'(cyc), 32'd4);
    chk("b2b second s", 32'(s), 32'h0002);

    // reset mid-run aborts and clears outputs left from a cout=1/ovf=1 result
    apply_start(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done(10, cyc);
    chk("pre-abort cout,ovf", 32'({cout, ovf}), 32'b11);
    apply_start(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort s", 32'(s), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort no done", 32'(done_cnt), 32'd0);

    for (int i = 0; i < 60000 && sweep_left != 0; i++) @(posedge clk);
    chk("sweeps finished", 32'(sweep_left), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Parameter sweep, one instance per configuration, running concurrently
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 3) ? 8 : 16;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 16 : 8;
    localparam int N = W / D;

    logic         rst_s, start_s, sub_s, cin_s, busy_s, done_s, cout_s, ovf_s;
    logic [W-1:0] a_s, b_s, s_s;

    serial_addr #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst_s), .start(start_s), .sub(sub_s), .a(a_s), .b(b_s), .cin(cin_s),
      .busy(busy_s), .done(done_s), .s(s_s), .cout(cout_s), .ovf(ovf_s)
    );

    initial begin
      logic [15:0]  es;
      bit           ec, eo;
      int           lat;
      logic [W-1:0] got_s;
      logic         got_c, got_o;

      rst_s = 1'b1; start_s = 1'b0; sub_s = 1'b0; cin_s = 1'b0; a_s = '0; b_s = '0;
      repeat (2) @(posedge clk);
      #1 rst_s = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        a_s = W'($urandom); b_s = W'($urandom);
        sub_s = 1'($urandom); cin_s = 1'($urandom);
        ref_model(W, 16'(a_s), 16'(b_s), cin_s, sub_s, es, ec, eo);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        a_s = W'($urandom); b_s = W'($urandom);
        lat = -1;
        got_s = 'x; got_c = 1'bx; got_o = 1'bx;
        for (int k = 1; k <= N + 4; k++) begin
          @(posedge clk); #1;
          if (done_s) begin
            lat = k;
            got_s = s_s; got_c = cout_s; got_o = ovf_s;
            break;
          end
        end
        chk($sformatf("sweep W%0d D%0d #%0d latency", W, D, i), 32'(lat), 32'(N));
        chk($sformatf("sweep W%0d D%0d #%0d s", W, D, i), 32'(got_s), 32'(es[W-1:0]));
        chk($sformatf("sweep W%0d D%0d #%0d cout,ovf", W, D, i), 32'({got_c, got_o}), 32'({ec, eo}));
      end
      sweep_left--;
    end
  end
endmodule
